// File: rtl/posit_mul_arbiter.sv
// Round-robin arbiter sharing one combinational posit multiplier among NREQ requesters.
// Define POSIT_MUL_ARB_NAR_CNT_EN to enable the saturating NaR result counter on nar_count.
module posit_mul_arbiter #(
    parameter int BITS = 32,
    parameter int ES   = 3,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*BITS-1:0] req_x,
    input  logic [NREQ*BITS-1:0] req_y,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BITS-1:0]      rsp_posit,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          nar_count
);
    localparam int unsigned MW = BITS - ES + 1;
    localparam int unsigned PW = 2 * MW;
    localparam int unsigned FW = PW - 1;
    localparam int unsigned LW = BITS + ES + FW + 1;
    localparam logic [BITS-1:0] NAR = {1'b1, {(BITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

    state_t          state, state_next;
    logic            accept;
    logic [IDW-1:0]  last, win;
    logic            found;
    int              idx;
    logic [BITS-1:0] op_x, op_y, product;
    logic [IDW-1:0]  op_id;

    // Split a non-special posit into its total scale and 1.f mantissa.
    function automatic void decode(input logic [BITS-1:0] p, output int scl,
                                   output logic [MW-1:0] mant);
        logic [BITS-1:0] a;
        logic [BITS-1:0] rem;
        int              run;
        logic            done;
        a    = p[BITS-1] ? -p : p;
        run  = 0;
        done = 1'b0;
        for (int i = BITS - 2; i >= 0; i--) begin
            if (!done && a[i] == a[BITS-2]) run++;
            else done = 1'b1;
        end
        rem  = a << (run + 2);
        scl  = (a[BITS-2] ? run - 1 : -run) * (1 << ES) + int'(rem[BITS-1 -: ES]);
        mant = {1'b1, rem[BITS-ES-1:0]};
    endfunction

    int              sx, sy, scl, k, rlen;
    logic [MW-1:0]   mx, my;
    logic [PW-1:0]   prod;
    logic [FW-1:0]   frac;
    logic [LW-1:0]   str, tail;
    logic [BITS-2:0] body;
    logic            guard, sticky, sgn;

    // Shared multiplier: exact product, regime/exponent/fraction re-encoded, round to nearest even.
    always_comb begin
        sx   = 0;
        sy   = 0;
        mx   = '0;
        my   = '0;
        sgn  = op_x[BITS-1] ^ op_y[BITS-1];
        decode(op_x, sx, mx);
        decode(op_y, sy, my);
        prod = PW'(mx) * PW'(my);
        if (prod[PW-1]) begin
            scl  = sx + sy + 1;
            frac = prod[PW-2:0];
        end else begin
            scl  = sx + sy;
            frac = {prod[PW-3:0], 1'b0};
        end
        k    = scl >>> ES;
        tail = {ES'(scl), frac, {(LW-ES-FW){1'b0}}};
        if (k >= 0) begin
            str  = ~({LW{1'b1}} >> (k + 1));
            rlen = k + 2;
        end else begin
            str  = {1'b1, {(LW-1){1'b0}}} >> (-k);
            rlen = 1 - k;
        end
        str    = str | (tail >> rlen);
        body   = str[LW-1 -: BITS-1];
        guard  = str[LW-BITS];
        sticky = |str[LW-BITS-1:0];
        body   = body + (BITS-1)'(guard & (sticky | body[0]));
        // Posits saturate at maxpos/minpos instead of overflowing or flushing to zero.
        if (k > BITS - 2) body = '1;
        else if (k < 2 - BITS) body = {{(BITS-2){1'b0}}, 1'b1};
        product = sgn ? -{1'b0, body} : {1'b0, body};
        if (op_x == NAR || op_y == NAR) product = NAR;
        else if (op_x == '0 || op_y == '0) product = '0;
    end

    // Round-robin scan starting just after the last winner.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int j = 1; j <= NREQ; j++) begin
            idx = (int'(last) + j) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign req_ready = (state == IDLE && found) ? (NREQ'(1) << win) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: if (found) begin
                accept     = 1'b1;
                state_next = MUL;
            end
            MUL:  state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_x      <= '0;
            op_y      <= '0;
            op_id     <= '0;
            last      <= IDW'(NREQ - 1);
            rsp_valid <= 1'b0;
            rsp_posit <= '0;
            rsp_id    <= '0;
        end else begin
            if (accept) begin
                op_x  <= req_x[int'(win)*BITS +: BITS];
                op_y  <= req_y[int'(win)*BITS +: BITS];
                op_id <= win;
                last  <= win;
            end
            if (state == MUL) begin
                rsp_posit <= product;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef POSIT_MUL_ARB_NAR_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) nar_count <= '0;
        else if (rsp_valid && rsp_ready && rsp_posit == NAR && nar_count != 16'hFFFF)
            nar_count <= nar_count + 16'd1;
    end
`else
    assign nar_count = 16'h0000;
`endif

endmodule

// File: tb/tb_posit_mul_arbiter.sv
// Scoreboard bench for posit_mul_arbiter: grants push expected results, a monitor pops on each handshake.
module tb_posit_mul_arbiter;
    localparam int BITS = 32;
    localparam int ES   = 3;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*BITS-1:0] req_x;
    logic [NREQ*BITS-1:0] req_y;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [BITS-1:0]      rsp_posit;
    logic [IDW-1:0]       rsp_id;
    logic [15:0]          nar_count;

    posit_mul_arbiter #(.BITS(BITS), .ES(ES), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_posit(rsp_posit), .rsp_id(rsp_id), .nar_count(nar_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int grant_cyc = 0;
    logic [IDW+BITS-1:0] exp_q[$];
    logic [BITS-1:0]     exp_p[NREQ];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: every response handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [IDW+BITS-1:0] e;
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e[IDW+BITS-1:BITS]));
                check("rsp_posit", 64'(rsp_posit), 64'(e[BITS-1:0]));
            end
        end
    end

    task automatic set_slot(input int id, input logic [BITS-1:0] x, input logic [BITS-1:0] y,
                            input logic [BITS-1:0] e);
        req_x[id*BITS +: BITS] = x;
        req_y[id*BITS +: BITS] = y;
        exp_p[id] = e;
    endtask

    task automatic wait_grant(input logic [NREQ-1:0] want, input string name);
        int n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(req_ready), 64'(want));
        for (int i = 0; i < NREQ; i++)
            if (req_ready[i]) exp_q.push_back({IDW'(i), exp_p[i]});
        grant_cyc = cyc;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        @(negedge clk);
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int id, input logic [BITS-1:0] x, input logic [BITS-1:0] y,
                         input logic [BITS-1:0] e, input string name);
        set_slot(id, x, y, e);
        req_valid[id] = 1'b1;
        wait_grant(NREQ'(1) << id, name);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        wait_drain(name);
    endtask

    localparam int NV = 11;
    int              vid[NV] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    logic [BITS-1:0] vx[NV]  = '{32'hC0000000, 32'h00000000, 32'h80000000, 32'h40000000,
                                 32'h80000000, 32'h42000000, 32'h44000000, 32'h7FFFFFFF,
                                 32'h00000001, 32'hBE000000, 32'h7FFFFFFF};
    logic [BITS-1:0] vy[NV]  = '{32'h40000000, 32'hC0000000, 32'h40000000, 32'h80000000,
                                 32'h00000000, 32'h42000000, 32'h44000000, 32'h7FFFFFFF,
                                 32'h00000001, 32'h42000000, 32'h00000001};
    logic [BITS-1:0] vp[NV]  = '{32'hC0000000, 32'h00000000, 32'h80000000, 32'h80000000,
                                 32'h80000000, 32'h44800000, 32'h48000000, 32'h7FFFFFFF,
                                 32'h00000001, 32'hBB800000, 32'h40000000};
    int              order[5] = '{0, 1, 2, 3, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int hs_cyc;
        int n;
        logic [IDW+BITS-1:0] dropped;
        rst_n = 1'b0;
        req_valid = '0;
        req_x = '0;
        req_y = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) exp_p[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_posit", 64'(rsp_posit), 64'd0);
        check("reset_rsp_id", 64'(rsp_id), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_nar_count", 64'(nar_count), 64'd0);

        // Single op with latency checks
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        set_slot(0, 32'h40000000, 32'h40000000, 32'h40000000);
        req_valid = 4'b0001;
        wait_grant(4'b0001, "single_grant");
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check("single_lat_mul", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("single_lat_resp", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        check("single_back_idle", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;

        // Arithmetic vectors including specials and saturation boundaries
        for (int v = 0; v < NV; v++) do_op(vid[v], vx[v], vy[v], vp[v], $sformatf("vec%0d", v));
`ifdef POSIT_MUL_ARB_NAR_CNT_EN
        check("nar_count", 64'(nar_count), 64'd3);
`else
        check("nar_count", 64'(nar_count), 64'd0);
`endif

        // Round robin with all requesters asserting
        set_slot(0, 32'h40000000, 32'h40000000, 32'h40000000);
        set_slot(1, 32'h44000000, 32'h44000000, 32'h48000000);
        set_slot(2, 32'h42000000, 32'h42000000, 32'h44800000);
        set_slot(3, 32'hC0000000, 32'h40000000, 32'hC0000000);
        req_valid = 4'b1111;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_grant(NREQ'(1) << order[g], $sformatf("rr_grant%0d", g));
            if (g > 0) check("rr_gap", 64'(grant_cyc - prev), 64'd3);
            prev = grant_cyc;
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        wait_drain("rr");

        // Backpressure: response held while requester 2 waits
        rsp_ready = 1'b0;
        set_slot(1, 32'h42000000, 32'h42000000, 32'h44800000);
        req_valid[1] = 1'b1;
        wait_grant(4'b0010, "bp_grant");
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        set_slot(2, 32'h44000000, 32'h44000000, 32'h48000000);
        req_valid[2] = 1'b1;
        n = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_posit", 64'(rsp_posit), 64'h44800000);
            check("bp_hold_id", 64'(rsp_id), 64'd1);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        hs_cyc = cyc;
        wait_grant(4'b0100, "bp_next_grant");
        check("bp_next_cycle", 64'(grant_cyc - hs_cyc), 64'd1);
        @(posedge clk);
        #1 req_valid = '0;
        wait_drain("bp");

        // Reset while the multiplier holds an in-flight op
        set_slot(1, 32'h40000000, 32'h40000000, 32'h40000000);
        req_valid[1] = 1'b1;
        wait_grant(4'b0010, "rst_pre_grant");
        dropped = exp_q.pop_back();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_posit", 64'(rsp_posit), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_nar_count", 64'(nar_count), 64'd0);
        repeat (4) @(negedge clk);
        check("rst_no_rsp", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        set_slot(0, 32'h40000000, 32'h40000000, 32'h40000000);
        set_slot(1, 32'h44000000, 32'h44000000, 32'h48000000);
        set_slot(2, 32'hBE000000, 32'h42000000, 32'hBB800000);
        req_valid = 4'b0111;
        for (int g = 0; g < 3; g++) begin
            wait_grant(NREQ'(1) << g, $sformatf("rst_post_grant%0d", g));
            @(posedge clk);
            #1 req_valid[g] = 1'b0;
        end
        wait_drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
